// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: holds {pc, instr, misaligned}
// entries in FIFO order, stalls fetch when full and flushes on a taken branch.
module if_id_queue #(
    parameter int                   DEPTH   = 2,
    parameter int                   PC_W    = 64,
    parameter int                   INSTR_W = 32,
    parameter logic [INSTR_W-1:0]   NOP     = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         branch_en,
    input  logic                         in_valid,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [INSTR_W-1:0]           in_instr,
    output logic                         fetch_stall,
    output logic                         out_valid,
    output logic [PC_W-1:0]              out_pc,
    output logic [INSTR_W-1:0]           out_instr,
    output logic                         out_misaligned,
    input  logic                         dec_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic               mis_mem_q   [DEPTH];
    logic               mis_mem_d   [DEPTH];

    logic full;
    logic push;
    logic pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        push = in_valid & ~full & ~branch_en;
        pop  = (count_q != '0) & dec_ready & ~branch_en;
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (branch_en) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        mis_mem_d   = mis_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]    = in_pc;
            instr_mem_d[wr_ptr_q] = in_instr;
            mis_mem_d[wr_ptr_q]   = (in_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
        mis_mem_q   <= mis_mem_d;
    end

    always_comb begin
        out_valid      = (count_q != '0);
        fetch_stall    = full;
        occupancy      = count_q;
        out_pc         = '0;
        out_instr      = NOP;
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_pc         = pc_mem_q[rd_ptr_q];
            out_instr      = instr_mem_q[rd_ptr_q];
            out_misaligned = mis_mem_q[rd_ptr_q];
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_ptr_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_ptr_q <= PTR_W'(DEPTH - 1)) && (wr_ptr_q <= PTR_W'(DEPTH - 1)));

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios then random traffic, scoreboarded
// against a queue-based model of the instruction buffer.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        fetch_stall;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misaligned;
  logic        dec_ready = 1'b0;
  logic [1:0]  occupancy;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  ent_t exp_q[$];
  ent_t pend;
  bit   pend_v = 1'b0;

  if_id_queue #(.DEPTH(DEPTH), .PC_W(64), .INSTR_W(32), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .branch_en(branch_en),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .fetch_stall(fetch_stall), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_misaligned(out_misaligned),
    .dec_ready(dec_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. An accepted fetch enters the model only after the
  // edge that captures it, so the monitor never sees it early.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                     input logic br, input logic rdy);
    @(posedge clk);
    #2;
    if (pend_v) exp_q.push_back(pend);
    pend_v    = 1'b0;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    branch_en = br;
    dec_ready = rdy;
    if (v && !br && exp_q.size() < DEPTH) begin
      pend.pc    = pc;
      pend.instr = ins;
      pend.mis   = (pc % 4) != 0;
      pend_v     = 1'b1;
    end
  endtask

  // Monitor: compare outputs to the model head, then apply this cycle's
  // flush or consumption to the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("fetch_stall", 64'(fetch_stall), 64'(exp_q.size() == DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        chk("out_misaligned", 64'(out_misaligned), 64'(exp_q[0].mis));
      end else begin
        chk("empty_pc", out_pc, 64'h0);
        chk("empty_instr", 64'(out_instr), 64'(NOP));
        chk("empty_mis", 64'(out_misaligned), 64'h0);
      end
      if (branch_en) exp_q.delete();
      else if (exp_q.size() != 0 && dec_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    // Reset held with fetch active: nothing may be captured.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_pc    = 64'h4;
    in_instr = 32'h1111_1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));
    chk("rst_fetch_stall", 64'(fetch_stall), 64'h0);
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    in_valid = 1'b0;
    mon_en   = 1'b1;

    // Stream with decode always ready.
    cyc(1, 64'h4, 32'hA000_0001, 0, 1);
    cyc(1, 64'h8, 32'hA000_0002, 0, 1);
    cyc(1, 64'hC, 32'hA000_0003, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 1);

    // Fill, refused offer, then a single pop.
    cyc(1, 64'h4, 32'hB000_0001, 0, 0);
    cyc(1, 64'h8, 32'hB000_0002, 0, 0);
    cyc(1, 64'hC, 32'hB000_0003, 0, 0);
    cyc(1, 64'hC, 32'hB000_0003, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 0);
    cyc(0, 64'h0, 32'h0, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 1);

    // Flush with a wrong-path fetch, then the branch target.
    cyc(1, 64'h10, 32'hC000_0001, 0, 0);
    cyc(1, 64'h14, 32'hC000_0002, 0, 0);
    cyc(1, 64'h18, 32'hC000_0003, 1, 1);
    cyc(1, 64'h0, 32'hC000_0004, 0, 0);
    cyc(0, 64'h0, 32'h0, 0, 1);

    // Misaligned PC keeps its instruction word.
    cyc(1, 64'h25, 32'hD000_0025, 0, 0);
    cyc(0, 64'h0, 32'h0, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 1);

    // Asynchronous reset between edges with two entries held.
    cyc(1, 64'h40, 32'hE000_0001, 0, 0);
    cyc(1, 64'h44, 32'hE000_0002, 0, 0);
    cyc(0, 64'h0, 32'h0, 0, 0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'h0);
    chk("async_occupancy", 64'(occupancy), 64'h0);
    chk("async_fetch_stall", 64'(fetch_stall), 64'h0);
    chk("async_out_instr", 64'(out_instr), 64'(NOP));
    exp_q.delete();
    pend_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    mon_en = 1'b1;

    // Random traffic: wraps pointers many times, mixes flushes and stalls.
    for (int i = 0; i < 2000; i++) begin
      cyc(logic'($urandom_range(0, 9) < 7),
          {$urandom, $urandom},
          $urandom,
          logic'($urandom_range(0, 19) == 0),
          logic'($urandom_range(0, 9) < 6));
    end
    cyc(0, 64'h0, 32'h0, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 1);
    cyc(0, 64'h0, 32'h0, 0, 1);
    @(posedge clk);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
